uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receive stage paired with the uart transmit stage: samples the async rx line,
//  deframes start/8 data/optional odd parity/stop, presents each byte on a valid/ready port.
//  Sits between the board rx pin and the command/readback logic; bad frames are dropped and flagged.
// PARAMETERS
//  CLK_FREQ   50000000  system clock frequency, Hz
//  BR         115200    baud rate; BAUD_DIV = CLK_FREQ/BR (integer division, 434 at defaults)
//  CHEAK      1         1: parity bit present after data (odd parity, expected bit = ~^data); 0: no parity bit
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  rx         in   1  serial input, asynchronous to clk, idle high
//  rx_data    out  8  received byte, stable while rx_vld=1
//  rx_vld     out  1  rx_data holds an unconsumed byte
//  rx_rdy     in   1  consumer accepts rx_data when rx_vld&&rx_rdy
//  parity_err out  1  one-cycle pulse: parity mismatch, byte dropped
//  frame_err  out  1  one-cycle pulse: stop bit sampled 0, byte dropped
//  overrun    out  1  one-cycle pulse: good byte completed while holding register still full, new byte dropped
// BEHAVIOUR
//  Reset: rx_data=0, rx_vld=0, all error pulses=0, FSM=IDLE, counters=0, both rx sync flops=1.
//  rx passes through 2-flop synchroniser; start detect = falling edge of synchronised rx (prev 1, now 0).
//  Baud counter: 0..BAUD_DIV-1, width $clog2(BAUD_DIV)+1, cleared on every state entry.
//  FSM:
//   IDLE   : on falling edge -> START.
//   START  : at count BAUD_DIV/2 sample; 0 -> DATA (bit idx=0), 1 -> IDLE (glitch, no flag).
//   DATA   : sample every BAUD_DIV cycles, LSB first into shift reg; after bit 7 -> PARITY if CHEAK else STOP.
//   PARITY : sample after BAUD_DIV; store mismatch (sample != ~^data) -> STOP.
//   STOP   : sample after BAUD_DIV (mid stop bit) -> IDLE, same cycle as commit decision.
//  Commit (stop sample cycle): stop=0 -> frame_err next cycle (frame_err wins if parity also bad);
//   else parity mismatch -> parity_err next cycle; else byte good.
//  Good byte: if rx_vld=0, or rx_vld&&rx_rdy in same cycle -> rx_data<=byte, rx_vld<=1 (latency 1 cycle
//   after stop sample); if rx_vld&&!rx_rdy -> overrun pulse, rx_data unchanged.
//  rx_vld drops the cycle after rx_vld&&rx_rdy unless replaced in that same cycle; rx_rdy ignored when rx_vld=0.
//  Errored frames never touch rx_data/rx_vld.
//  Line held low (break): one frame_err, then IDLE waits for a new 1->0 edge; no further frames.
//  Falling edges during START/DATA/PARITY/STOP are ignored (no resync mid-frame).
//  Reset asserted mid-frame: immediate return to reset values; partial byte discarded, no flags.
//  Next start bit accepted from the cycle FSM reaches IDLE (half-bit stop tolerance).
// TESTING  (sim params CLK_FREQ=1000000, BR=100000 -> BAUD_DIV=10, CHEAK=1 unless noted)
//  1) send 0xA5 parity 1 stop 1, rx_rdy=1 -> rx_vld high 1 cycle, rx_data=0xA5, no error pulses.
//  2) send 0x3C with parity bit flipped -> parity_err one pulse, rx_vld stays 0.
//  3) send 0x55 with stop=0 then line high -> frame_err one pulse, rx_vld 0; next 0x12 received clean.
//  4) rx_rdy=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulse at 2nd byte; rx_rdy=1 -> 0x11 consumed.
//  5) 3-cycle low glitch on idle rx -> no rx_vld, no error; rst pulse during bit 4 of a frame -> all outputs 0, following frame 0x7E received.
//  6) CHEAK=0, back-to-back 0x00,0xFF with no idle gap, rx_rdy=1 -> two rx_vld pulses, data 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Serial receive stage. The asynchronous rx pin goes through a two-flop
//   synchroniser, and a falling edge on the synchronised line starts a frame:
//   start bit, 8 data bits LSB first, an optional odd parity bit, then a stop
//   bit. Each good byte is offered on a valid/ready holding register. Bad
//   frames are dropped and raise a one-cycle error pulse.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BR        baud rate; one bit time is CLK_FREQ/BR clocks
//   CHEAK     1: a parity bit follows the data (odd parity); 0: no parity bit
//
// Ports
//   clk         in   system clock; all logic runs on the rising edge
//   rst         in   asynchronous active-high reset
//   rx          in   serial input, asynchronous to clk, idles high
//   rx_data     out  received byte, stable while rx_vld is high
//   rx_vld      out  rx_data holds a byte that has not been consumed
//   rx_rdy      in   consumer takes rx_data when rx_vld && rx_rdy
//   parity_err  out  one-cycle pulse: parity mismatch, byte dropped
//   frame_err   out  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun     out  one-cycle pulse: good byte arrived while the holding
//                    register was still full, new byte dropped
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BR       = 115200,
  parameter bit CHEAK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_DIV = CLK_FREQ / BR;
  localparam int CW       = $clog2(BAUD_DIV) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Expected value of the parity bit for odd parity over the data byte.
  function automatic logic odd_parity_bit(input logic [7:0] d);
    return ~^d;
  endfunction

  logic          rx_s1_q,      rx_s2_q,      rx_prev_q;
  state_t        state_q,      state_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [2:0]    bit_idx_q,    bit_idx_d;
  logic [7:0]    shift_q,      shift_d;
  logic          par_bad_q,    par_bad_d;
  logic [7:0]    rx_data_q,    rx_data_d;
  logic          rx_vld_q,     rx_vld_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q,  frame_err_d;
  logic          overrun_q,    overrun_d;
  logic          fall_s;

  // Start condition: synchronised line was high last cycle and is low now.
  assign fall_s = rx_prev_q & ~rx_s2_q;

  // Next-state, bit sampling and commit decision for the receive FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    // A handshake empties the holding register unless a new byte replaces it below.
    if (rx_vld_q && rx_rdy) begin
      rx_vld_d = 1'b0;
    end else begin
      rx_vld_d = rx_vld_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      // Re-check the line at mid start bit so short glitches are rejected silently.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s2_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
            par_bad_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // From mid start bit, every full bit time lands in the middle of the next bit.
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            if (CHEAK) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rx_s2_q != odd_parity_bit(shift_q));
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Stop sample is also the commit point; a framing error masks a parity error.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s2_q) begin
            frame_err_d = 1'b1;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
          end else if (!rx_vld_q || rx_rdy) begin
            rx_data_d = shift_q;
            rx_vld_d  = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_vld_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_vld_q     <= rx_vld_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_vld     = rx_vld_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Two receivers share the clock and reset: dut_a has a parity bit, dut_b
//   does not. Frames are driven bit by bit. For each frame the bench works out
//   the outcome (good / parity error / framing error) and the clock edge at
//   which it must appear. A per-cycle model of the valid/ready holding register
//   turns those outcomes into expected outputs, and every cycle all outputs of
//   both receivers are compared against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BR       = 100000;
  localparam int D        = CLK_FREQ / BR;
  // Frame start edge to output edge: 2 sync stages + 1 edge-detect register,
  // half a bit to mid start bit, then one bit time per data/parity/stop bit.
  localparam int LAT_PAR   = 3 + D/2 + 10*D;
  localparam int LAT_NOPAR = 3 + D/2 + 9*D;

  typedef enum int {EV_GOOD, EV_PERR, EV_FERR} kind_t;
  typedef struct {
    int         at;
    int         inst;
    kind_t      kind;
    logic [7:0] data;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx_a  = 1'b1;
  logic       rdy_a = 1'b0;
  logic       rx_b  = 1'b1;
  logic       rdy_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BR(BR), .CHEAK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_vld(vld_a),
    .rx_rdy(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BR(BR), .CHEAK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_vld(vld_b),
    .rx_rdy(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  ev_t        evq[$];
  ev_t        cur_e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_vld[2], m_perr[2], m_ferr[2], m_ovr[2], m_good[2];
  logic [7:0] m_data[2], m_gdata[2];
  logic       rdy_s;
  int         n_vld[2], n_perr[2], n_ferr[2], n_ovr[2], last_rise[2];
  logic       prev_vld[2];
  logic [7:0] last_byte[2];
  logic [7:0] cap_b[$];
  int         k, base0, base1, base2, base3;
  logic [7:0] rd;
  logic       rflip, rstop;
  int         rgap;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else           rx_b = v;
  endtask

  // Called at a negedge; returns at a negedge. The start bit is first sampled at edge k.
  task automatic send_frame(input int inst, input logic [7:0] d, input logic flip,
                            input logic stopb, input int gap, output int k_o);
    logic [10:0] bits;
    int          nb;
    ev_t         e;
    nb      = (inst == 0) ? 11 : 10;
    bits    = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (inst == 0) begin
      bits[9]  = (~^d) ^ flip;
      bits[10] = stopb;
    end else begin
      bits[9] = stopb;
    end
    k_o    = cyc + 1;
    e.at   = k_o + ((inst == 0) ? LAT_PAR : LAT_NOPAR);
    e.inst = inst;
    e.data = d;
    if (!stopb)                  e.kind = EV_FERR;
    else if (inst == 0 && flip)  e.kind = EV_PERR;
    else                         e.kind = EV_GOOD;
    evq.push_back(e);
    for (int j = 0; j < nb; j++) begin
      set_line(inst, bits[j]);
      repeat (D) @(negedge clk);
    end
    set_line(inst, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_vld[s] = 1'b0; m_data[s] = 8'h00; m_perr[s] = 1'b0; m_ferr[s] = 1'b0;
      m_ovr[s] = 1'b0; n_vld[s] = 0; n_perr[s] = 0; n_ferr[s] = 0; n_ovr[s] = 0;
      last_rise[s] = 0; prev_vld[s] = 1'b0; last_byte[s] = 8'h00;
    end

    fork
      forever begin
        @(posedge clk);
        cyc = cyc + 1;
        for (int s = 0; s < 2; s++) begin
          m_good[s] = 1'b0; m_perr[s] = 1'b0; m_ferr[s] = 1'b0; m_ovr[s] = 1'b0;
        end
        if (rst) begin
          for (int s = 0; s < 2; s++) begin
            m_vld[s] = 1'b0; m_data[s] = 8'h00;
          end
          evq.delete();
        end else begin
          while (evq.size() > 0 && evq[0].at <= cyc) begin
            cur_e = evq.pop_front();
            if (cur_e.at != cyc) check("event_missed", cur_e.at, cyc);
            case (cur_e.kind)
              EV_GOOD: begin m_good[cur_e.inst] = 1'b1; m_gdata[cur_e.inst] = cur_e.data; end
              EV_PERR: m_perr[cur_e.inst] = 1'b1;
              default: m_ferr[cur_e.inst] = 1'b1;
            endcase
          end
          for (int s = 0; s < 2; s++) begin
            rdy_s = (s == 0) ? rdy_a : rdy_b;
            if (m_good[s]) begin
              if (!m_vld[s] || rdy_s) begin
                m_data[s] = m_gdata[s];
                m_vld[s]  = 1'b1;
              end else begin
                m_ovr[s] = 1'b1;
              end
            end else if (m_vld[s] && rdy_s) begin
              m_vld[s] = 1'b0;
            end
          end
        end
        #1;
        check("a_rx_vld",     vld_a,  m_vld[0]);
        check("a_rx_data",    data_a, m_data[0]);
        check("a_parity_err", perr_a, m_perr[0]);
        check("a_frame_err",  ferr_a, m_ferr[0]);
        check("a_overrun",    ovr_a,  m_ovr[0]);
        check("b_rx_vld",     vld_b,  m_vld[1]);
        check("b_rx_data",    data_b, m_data[1]);
        check("b_parity_err", perr_b, m_perr[1]);
        check("b_frame_err",  ferr_b, m_ferr[1]);
        check("b_overrun",    ovr_b,  m_ovr[1]);
        if (vld_a) begin n_vld[0] = n_vld[0] + 1; last_byte[0] = data_a; end
        if (vld_a && !prev_vld[0]) last_rise[0] = cyc;
        if (vld_b) begin n_vld[1] = n_vld[1] + 1; last_byte[1] = data_b; end
        if (vld_b && rdy_b) cap_b.push_back(data_b);
        if (perr_a) n_perr[0] = n_perr[0] + 1;
        if (ferr_a) n_ferr[0] = n_ferr[0] + 1;
        if (ovr_a)  n_ovr[0]  = n_ovr[0] + 1;
        prev_vld[0] = vld_a;
        prev_vld[1] = vld_b;
        if (cyc > 60000) begin
          $display("FAIL watchdog: got cycle %0d expected below 60000", cyc);
          $fatal(1, "watchdog expired");
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_vld",  vld_a,  1'b0);
    check("reset_data", data_a, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1) clean 0xA5, consumer ready
    rdy_a = 1'b1;
    base0 = n_vld[0];
    send_frame(0, 8'hA5, 1'b0, 1'b1, 20, k);
    check("t1_vld_cycles", n_vld[0] - base0, 1);
    check("t1_byte",       last_byte[0], 8'hA5);
    check("t1_latency",    last_rise[0] - k, 108);

    // 2) 0x3C with flipped parity
    base0 = n_vld[0]; base1 = n_perr[0];
    send_frame(0, 8'h3C, 1'b1, 1'b1, 20, k);
    check("t2_perr_pulses", n_perr[0] - base1, 1);
    check("t2_no_vld",      n_vld[0] - base0, 0);

    // 3) 0x55 with stop low, then clean 0x12
    base0 = n_vld[0]; base2 = n_ferr[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 20, k);
    check("t3_ferr_pulses", n_ferr[0] - base2, 1);
    check("t3_no_vld",      n_vld[0] - base0, 0);
    send_frame(0, 8'h12, 1'b0, 1'b1, 20, k);
    check("t3_next_byte",   last_byte[0], 8'h12);

    // 4) overrun while holding register is full
    rdy_a = 1'b0;
    base3 = n_ovr[0];
    send_frame(0, 8'h11, 1'b0, 1'b1, 10, k);
    send_frame(0, 8'h22, 1'b0, 1'b1, 10, k);
    check("t4_ovr_pulses", n_ovr[0] - base3, 1);
    check("t4_held_data",  data_a, 8'h11);
    check("t4_held_vld",   vld_a, 1'b1);
    rdy_a = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_consumed",   vld_a, 1'b0);

    // Break: line low for three frame times gives a single frame error
    base2 = n_ferr[0];
    k = cyc + 1;
    cur_e.at = k + LAT_PAR; cur_e.inst = 0; cur_e.kind = EV_FERR; cur_e.data = 8'h00;
    evq.push_back(cur_e);
    rx_a = 1'b0;
    repeat (33 * D) @(negedge clk);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    check("brk_ferr_pulses", n_ferr[0] - base2, 1);

    // 5a) 3-cycle glitch on idle line
    base0 = n_vld[0] + n_perr[0] + n_ferr[0] + n_ovr[0];
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * D) @(negedge clk);
    check("t5_glitch_quiet", n_vld[0] + n_perr[0] + n_ferr[0] + n_ovr[0] - base0, 0);

    // 5b) reset in the middle of bit 4 of 0x5A, then 0x7E
    rd = 8'h5A;
    rx_a = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_a = rd[i];
      repeat ((i == 4) ? D/2 : D) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld",  vld_a,  1'b0);
    check("t5_rst_data", data_a, 8'h00);
    @(negedge clk);
    rst  = 1'b0;
    rx_a = 1'b1;
    repeat (3 * D) @(negedge clk);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 20, k);
    check("t5_after_rst", last_byte[0], 8'h7E);

    // Randomised frames on the parity receiver
    for (int n = 0; n < 24; n++) begin
      rd    = 8'($urandom_range(0, 255));
      rflip = ($urandom_range(0, 5) == 0);
      rstop = ($urandom_range(0, 7) != 0);
      rgap  = rstop ? $urandom_range(0, 12) : $urandom_range(1, 12);
      rdy_a = 1'($urandom_range(0, 1));
      send_frame(0, rd, rflip, rstop, rgap, k);
    end
    rdy_a = 1'b1;
    repeat (5) @(negedge clk);

    // 6) no-parity receiver, back-to-back 0x00 then 0xFF
    rdy_b = 1'b1;
    cap_b.delete();
    send_frame(1, 8'h00, 1'b0, 1'b1, 0, k);
    send_frame(1, 8'hFF, 1'b0, 1'b1, 20, k);
    check("t6_count",  cap_b.size(), 2);
    check("t6_first",  cap_b[0], 8'h00);
    check("t6_second", cap_b[1], 8'hFF);

    // Randomised frames on the no-parity receiver
    for (int n = 0; n < 10; n++) begin
      rd    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 5) != 0);
      rgap  = rstop ? $urandom_range(0, 8) : $urandom_range(1, 8);
      rdy_b = 1'($urandom_range(0, 1));
      send_frame(1, rd, 1'b0, rstop, rgap, k);
    end
    rdy_b = 1'b1;
    repeat (20) @(negedge clk);
    check("pending_events", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
